nn_shift_layer: RTL
===================

Name: nn_shift_layer

Overview:
- Parametrised fully-connected NN layer: NumNeurons neurons, each taking InputWidth signed activations.
- Weights are loaded through a serial shift chain (shift_i/weights_i/weights_o), so layers can be daisy-chained for configuration.
- Computes sequentially, one input per cycle, across all neurons in parallel.
- Adds fixed-point rescale, runtime-selectable ReLU, saturation flags and req/ack handshakes on input and output; successor to the single-layer simple_nn datapath.

Parameters:
- NumNeurons, 4, number of neurons/outputs.
- InputWidth, 8, activations per input vector.
- DataWidth, 8, signed activation/output width.
- WeightsWidth, 8, signed weight width.
- FracBits, 0, arithmetic right shift applied to accumulator before activation.
- AccWidth, DataWidth+WeightsWidth+$clog2(InputWidth), signed accumulator width.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- actv_i  in  DataWidth*InputWidth  input vector; element i at bits [i*DataWidth +: DataWidth].
- req_i  in  1  input vector valid.
- ack_o  out  1  layer ready; a transfer occurs when req_i && ack_o.
- relu_en_i  in  1  ReLU enable, sampled at the input handshake.
- output_o  out  DataWidth*NumOutputs(=NumNeurons)  result; neuron n at [n*DataWidth +: DataWidth].
- sat_o  out  NumNeurons  per-neuron saturation flag for the current result.
- req_o  out  1  result valid.
- ack_i  in  1  downstream accept; result consumed when req_o && ack_i.
- shift_i  in  1  weight shift enable.
- weights_i  in  WeightsWidth  serial weight in.
- weights_o  out  WeightsWidth  serial weight out (chain to next layer).

Behaviour:
- Weight store: W = NumNeurons*InputWidth signed words w[0..W-1].
  - w[n*InputWidth+i] is the weight for neuron n, input i.
  - On shift_i in IDLE: w[0] <= weights_i, w[k] <= w[k-1].
  - weights_o = w[W-1] (registered). The host therefore shifts w[W-1] first.
  - shift_i in MAC or OUT is ignored; weights are unchanged.
- Reset (any state, including mid-MAC or mid-OUT), effective next edge:
  - state IDLE, ack_o=1, req_o=0, output_o=0, sat_o=0;
  - accumulators, counter and all weights cleared to 0; weights_o=0.
- FSM:
  - IDLE: ack_o=1. On req_i: latch actv_i and relu_en_i, clear accumulators, cnt=0, go to MAC.
  - MAC: ack_o=0. Each cycle, for every n: acc[n] += actv[cnt]*w[n*InputWidth+cnt] (signed, full AccWidth, no overflow possible); cnt++. After the cnt==InputWidth-1 cycle go to OUT, registering results from the final accumulator values.
  - OUT: req_o=1, output_o and sat_o stable. On ack_i go to IDLE; req_o deasserts the next cycle.
- Latency: handshake at edge T; MAC occupies T+1..T+InputWidth; req_o high from cycle T+InputWidth+1. Throughput is one vector per InputWidth+2 cycles with ack_i tied high.
- Output arithmetic, per neuron:
  - s = acc >>> FracBits (arithmetic, floor).
  - If relu_en is set and s<0, then s=0.
  - Saturate to [-2^(DataWidth-1), 2^(DataWidth-1)-1]; sat_o[n]=1 iff clipping occurred. ReLU zeroing does not set sat_o.
- req_i while ack_o=0 is ignored; no buffering.
- ack_i while req_o=0 has no effect.
- A new input can never be accepted in the same cycle as an output ack; IDLE is always visited.

Test Plan (NumNeurons=2, InputWidth=4, DataWidth=WeightsWidth=8, FracBits=0):
- Shift chain: reset, then shift 0x01..0x08 over 8 cycles -> weights_o=0x01 after the 8th shift; 9th shift of 0x09 -> weights_o=0x02; shift_i low holds values.
- Basic MAC: all weights 1, actv={4,3,2,1} (elements 0..3 = 1,2,3,4), req_i at T -> ack_o low T+1..T+4, req_o at T+5, output_o={10,10}, sat_o=0.
- Saturation: all weights 127, all actv 127 -> acc 64516 -> output_o={127,127}, sat_o=2'b11; weights -128 with actv 127 -> -128 each, sat_o=11.
- ReLU mode: weights -1, actv 1,2,3,4: relu_en_i=0 -> outputs 0xF6 (-10); relu_en_i=1 -> outputs 0x00, sat_o=0.
- Backpressure/busy: hold ack_i low 10 cycles in OUT -> output_o/req_o stable, ack_o=0, toggling req_i and shift_i changes nothing; ack_i pulse -> req_o low next cycle, ack_o high.
- Reset mid-MAC: reset_i at T+2 -> next cycle IDLE, ack_o=1, req_o=0, weights_o=0; a following vector with zero weights gives output_o=0 at T'+5.

Source files
------------

// File: rtl/nn_shift_layer.sv
// Fully-connected layer: serially loaded weights, one input element per cycle
// MAC'd across all neurons in parallel, with rescale, optional ReLU and saturation.
module nn_shift_neuron #(
   parameter int DataWidth    = 8,
   parameter int WeightsWidth = 8,
   parameter int FracBits     = 0,
   parameter int AccWidth     = 19
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear,
   input  logic                           en,
   input  logic                           last,
   input  logic                           relu,
   input  logic signed [DataWidth-1:0]    a,
   input  logic signed [WeightsWidth-1:0] w,
   output logic        [DataWidth-1:0]    y,
   output logic                           sat
);
   localparam logic signed [AccWidth-1:0] MaxV = AccWidth'((1 << (DataWidth-1)) - 1);
   localparam logic signed [AccWidth-1:0] MinV = ~MaxV;

   logic signed [AccWidth-1:0] acc, acc_next, prod, s;
   logic        [DataWidth-1:0] y_next;
   logic                        sat_next;

   assign prod = AccWidth'(a) * AccWidth'(w);

   always_comb begin
      acc_next = acc + prod;
      s        = acc_next >>> FracBits;
      if (relu && s < 0) s = '0;
      y_next   = s[DataWidth-1:0];
      sat_next = 1'b0;
      if (s > MaxV) begin
         y_next   = MaxV[DataWidth-1:0];
         sat_next = 1'b1;
      end else if (s < MinV) begin
         y_next   = MinV[DataWidth-1:0];
         sat_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         y   <= '0;
         sat <= 1'b0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_next;
         // result is taken from the final sum, not the registered acc
         if (last) begin
            y   <= y_next;
            sat <= sat_next;
         end
      end
   end
endmodule

module nn_shift_layer #(
   parameter int NumNeurons   = 4,
   parameter int InputWidth   = 8,
   parameter int DataWidth    = 8,
   parameter int WeightsWidth = 8,
   parameter int FracBits     = 0,
   parameter int AccWidth     = DataWidth + WeightsWidth + $clog2(InputWidth)
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [DataWidth*InputWidth-1:0]  actv_i,
   input  logic                             req_i,
   output logic                             ack_o,
   input  logic                             relu_en_i,
   output logic [DataWidth*NumNeurons-1:0]  output_o,
   output logic [NumNeurons-1:0]            sat_o,
   output logic                             req_o,
   input  logic                             ack_i,
   input  logic                             shift_i,
   input  logic [WeightsWidth-1:0]          weights_i,
   output logic [WeightsWidth-1:0]          weights_o
);
   localparam int W    = NumNeurons * InputWidth;
   localparam int CntW = (InputWidth > 1) ? $clog2(InputWidth) : 1;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state_q, state_d;

   logic signed [WeightsWidth-1:0] w_q   [W];
   logic signed [DataWidth-1:0]    act_q [InputWidth];
   logic                           relu_q;
   logic [CntW-1:0]                cnt_q;
   logic                           start, last;

   assign start     = (state_q == IDLE) && req_i;
   assign last      = (state_q == MAC) && (cnt_q == CntW'(InputWidth-1));
   assign ack_o     = (state_q == IDLE);
   assign req_o     = (state_q == OUT);
   assign weights_o = w_q[W-1];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_i) state_d = MAC;
         MAC:     if (last)  state_d = OUT;
         OUT:     if (ack_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         relu_q  <= 1'b0;
         for (int k = 0; k < W; k++) w_q[k] <= '0;
         for (int i = 0; i < InputWidth; i++) act_q[i] <= '0;
      end else begin
         state_q <= state_d;
         // chain only moves while idle so a running MAC sees stable weights
         if (shift_i && state_q == IDLE) begin
            w_q[0] <= weights_i;
            for (int k = 1; k < W; k++) w_q[k] <= w_q[k-1];
         end
         if (start) begin
            cnt_q  <= '0;
            relu_q <= relu_en_i;
            for (int i = 0; i < InputWidth; i++)
               act_q[i] <= actv_i[i*DataWidth +: DataWidth];
         end else if (state_q == MAC) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   for (genvar n = 0; n < NumNeurons; n++) begin : g_neuron
      logic signed [WeightsWidth-1:0] row [InputWidth];
      for (genvar i = 0; i < InputWidth; i++) begin : g_row
         assign row[i] = w_q[n*InputWidth + i];
      end

      nn_shift_neuron #(
         .DataWidth   (DataWidth),
         .WeightsWidth(WeightsWidth),
         .FracBits    (FracBits),
         .AccWidth    (AccWidth)
      ) u_neuron (
         .clk  (clk_i),
         .reset(reset_i),
         .clear(start),
         .en   (state_q == MAC),
         .last (last),
         .relu (relu_q),
         .a    (act_q[cnt_q]),
         .w    (row[cnt_q]),
         .y    (output_o[n*DataWidth +: DataWidth]),
         .sat  (sat_o[n])
      );
   end
endmodule
